clause_fetch_sequencer: RTL and testbench
=========================================

// Module: clause_fetch_sequencer
// PURPOSE
//  Controller for the candidate-clause datapath in the SAT solver core.
//  Takes a clause index from the unsat-clause selector and issues one clause-memory read.
//  Captures the NSAT packed literals into its internal clause register.
//  Streams the literals one per handshake to the break-value evaluator, then pulses
//  clause_done_o so the selector can pick the next clause.
// PARAMETERS
//  NSAT                  3   literals per clause (lanes); >= 2
//  LITERAL_ADDRESS_WIDTH 11  variable address bits; literal word = LITERAL_ADDRESS_WIDTH+1 bits, MSB = negation
//  CLAUSE_ADDRESS_WIDTH  12  clause memory address bits
//  MEM_LATENCY           1   cycles from mem_rd_en_o to valid mem_data_i; >= 1
// PORTS
//  clk            in   1                            system clock, rising edge
//  reset          in   1                            asynchronous, active-low reset
//  flush          in   1                            synchronous abort to IDLE
//  start_i        in   1                            request fetch of clause_index_i; sampled only in IDLE
//  clause_index_i in   CLAUSE_ADDRESS_WIDTH         clause to fetch
//  busy_o         out  1                            high in any state other than IDLE
//  mem_rd_en_o    out  1                            one-cycle clause-memory read strobe
//  mem_addr_o     out  CLAUSE_ADDRESS_WIDTH         clause-memory address; held from accept until next start
//  mem_data_i     in   NSAT*(LITERAL_ADDRESS_WIDTH+1) packed clause; lane 0 in LSBs
//  lit_valid_o    out  1                            literal presented
//  lit_ready_i    in   1                            evaluator accepts literal
//  lit_addr_o     out  LITERAL_ADDRESS_WIDTH        variable address of current literal
//  lit_neg_o      out  1                            negation bit of current literal
//  lit_idx_o      out  max(1,$clog2(NSAT))          lane index of current literal
//  clause_done_o  out  1                            one-cycle pulse; all literals delivered
// BEHAVIOUR
//  Reset (reset==0, asynchronous): state=IDLE; all outputs 0; clause register and lane counter 0.
//  FSM states and transitions:
//   IDLE:   start_i=1 -> latch clause_index_i into mem_addr_o -> FETCH.
//   FETCH:  mem_rd_en_o=1 in the first FETCH cycle only. A latency counter counts MEM_LATENCY cycles.
//           In the last cycle, mem_data_i is captured into the clause register. Lane counter = first lane -> STREAM.
//   STREAM: lit_valid_o=1. Outputs are driven from the registered lane.
//           Handshake = lit_valid_o & lit_ready_i.
//           On a handshake at the last lane -> DONE; otherwise advance to the next lane.
//           Without a handshake, all lit_* outputs are held stable.
//   DONE:   clause_done_o=1 for exactly one cycle -> IDLE.
//  Timing, with MEM_LATENCY=1 and ready always high:
//   start accepted at cycle 0; mem_rd_en_o in cycle 1; lanes in cycles 3..2+NSAT; done in cycle 3+NSAT.
//   The next start is accepted no earlier than the following cycle.
//  start_i outside IDLE: ignored. No queueing.
//  flush (priority over all transitions except reset): next state IDLE; lit_valid_o, mem_rd_en_o and
//   clause_done_o drop the next cycle; no done pulse for the aborted clause; clause register is not cleared.
//  flush and start_i in the same IDLE cycle: flush wins; start is dropped.
//  Reset asserted mid-operation: immediate IDLE, as in the reset values above.
//  lit_ready_i is ignored when lit_valid_o=0. Lane counter wraps to 0 on entering DONE.
// CONFIGURATION
//  CLAUSE_SKIP_NULL_EN defined:
//   - A lane whose variable address is 0 is padding: never presented, skipped at zero cost.
//   - The first lane = lowest non-null lane; the last lane = highest non-null lane.
//   - An all-null clause goes FETCH -> DONE directly, with no lit_valid_o.
//  CLAUSE_SKIP_NULL_EN undefined: all NSAT lanes are streamed unconditionally, including address-0 lanes.
// TESTING
//  1. Reset, then start, index 5, NSAT=3, MEM_LATENCY=1, ready=1.
//     -> rd_en in cycle 1 with addr 5; lanes 0,1,2 in cycles 3,4,5; done in cycle 6.
//  2. Lane 1 = {neg=1, addr=0x07A}; hold ready=0 for 4 cycles on lane 1.
//     -> lit_addr_o=0x07A, lit_neg_o=1, lit_idx_o=1 stable all 4 cycles; lane 2 appears the cycle after ready.
//  3. start asserted during STREAM with index 9.
//     -> ignored; mem_addr_o stays 5; exactly one done pulse.
//  4. flush in the cycle lane 1 is valid.
//     -> lit_valid_o=0 the next cycle; no clause_done_o; a new start fetches correctly.
//  5. MEM_LATENCY=3.
//     -> lane 0 valid in cycle 5; captured data matches memory word 3 cycles after rd_en.
//  6. CLAUSE_SKIP_NULL_EN, clause {lane0=0x011, lane1=0, lane2=0x022}.
//     -> lit_idx_o sequence 0,2; an all-zero clause gives a done pulse with no lit_valid_o.

Source files
------------

// File: rtl/clause_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clause_fetch_sequencer
// Purpose  : Candidate-clause controller for the SAT solver core. It accepts
//            a clause index, issues one clause-memory read, captures the NSAT
//            packed literals and streams them one per valid/ready handshake
//            to the break-value evaluator. It then pulses clause_done_o.
// Ports    : clk, reset (async, active-low), flush (sync abort to IDLE)
//            start_i / clause_index_i   - fetch request (sampled in IDLE)
//            busy_o                     - not in IDLE
//            mem_rd_en_o / mem_addr_o   - clause-memory read strobe/address
//            mem_data_i                 - packed clause, lane 0 in LSBs
//            lit_valid_o / lit_ready_i  - literal handshake
//            lit_addr_o / lit_neg_o     - current literal fields
//            lit_idx_o                  - lane index of current literal
//            clause_done_o              - one-cycle end-of-clause pulse
// Config   : CLAUSE_SKIP_NULL_EN - when defined, lanes whose variable
//            address is 0 are padding and are skipped without cost.
// Revision : 1.0 - initial release
// ============================================================================
module clause_fetch_sequencer #(
  parameter int NSAT                  = 3,
  parameter int LITERAL_ADDRESS_WIDTH = 11,
  parameter int CLAUSE_ADDRESS_WIDTH  = 12,
  parameter int MEM_LATENCY           = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic                                      start_i,
  input  logic [CLAUSE_ADDRESS_WIDTH-1:0]           clause_index_i,
  output logic                                      busy_o,
  output logic                                      mem_rd_en_o,
  output logic [CLAUSE_ADDRESS_WIDTH-1:0]           mem_addr_o,
  input  logic [NSAT*(LITERAL_ADDRESS_WIDTH+1)-1:0] mem_data_i,
  output logic                                      lit_valid_o,
  input  logic                                      lit_ready_i,
  output logic [LITERAL_ADDRESS_WIDTH-1:0]          lit_addr_o,
  output logic                                      lit_neg_o,
  output logic [$clog2(NSAT)-1:0]                   lit_idx_o,
  output logic                                      clause_done_o
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int LAW  = LITERAL_ADDRESS_WIDTH;
  localparam int LW   = LITERAL_ADDRESS_WIDTH + 1;   // literal word, MSB = negation
  localparam int IDXW = $clog2(NSAT);                // NSAT >= 2, so IDXW >= 1
  localparam int LCW  = $clog2(MEM_LATENCY + 1);     // counts 0..MEM_LATENCY
  localparam int DW   = NSAT * LW;

  localparam logic [IDXW-1:0] LAST_LANE = IDXW'(NSAT - 1);
  localparam logic [LCW-1:0]  LAT_LAST  = LCW'(MEM_LATENCY);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                      state_q, state_d;
  logic [LCW-1:0]                  lat_cnt_q, lat_cnt_d;
  logic [IDXW-1:0]                 lane_q, lane_d;
  logic [DW-1:0]                   clause_q, clause_d;
  logic [CLAUSE_ADDRESS_WIDTH-1:0] addr_q, addr_d;

  // --------------------------------------------------------------------------
  // Control events
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_fetch_last;
  logic w_capture;
  logic w_handshake;

  // FETCH spans MEM_LATENCY+1 cycles: the strobe cycle plus MEM_LATENCY
  // cycles of wait; memory data is valid in the final one.
  assign w_accept     = (state_q == S_IDLE) & start_i & ~flush;
  assign w_fetch_last = (state_q == S_FETCH) & (lat_cnt_q == LAT_LAST);
  assign w_capture    = w_fetch_last & ~flush;
  assign w_handshake  = (state_q == S_STREAM) & lit_ready_i;

  // --------------------------------------------------------------------------
  // Lane sequencing: first lane of the incoming word, successor of the
  // current lane and whether the current lane is the final one.
  // --------------------------------------------------------------------------
  logic [IDXW-1:0] w_first_lane;
  logic            w_any_lane;
  logic [IDXW-1:0] w_next_lane;
  logic            w_is_last;

`ifdef CLAUSE_SKIP_NULL_EN
  logic w_has_next;

  // Scan from the top down so the lowest non-null lane wins.
  always_comb begin
    w_first_lane = '0;
    w_any_lane   = 1'b0;
    for (int i = NSAT - 1; i >= 0; i--) begin
      if (mem_data_i[i*LW +: LAW] != '0) begin
        w_first_lane = IDXW'(i);
        w_any_lane   = 1'b1;
      end
    end
  end

  // Lowest non-null lane strictly above the current one; none means the
  // current lane is the last to be presented.
  always_comb begin
    w_next_lane = '0;
    w_has_next  = 1'b0;
    for (int i = NSAT - 1; i >= 0; i--) begin
      if ((IDXW'(i) > lane_q) && (clause_q[i*LW +: LAW] != '0)) begin
        w_next_lane = IDXW'(i);
        w_has_next  = 1'b1;
      end
    end
  end

  assign w_is_last = ~w_has_next;
`else
  assign w_first_lane = '0;
  assign w_any_lane   = 1'b1;
  assign w_next_lane  = lane_q + IDXW'(1);
  assign w_is_last    = (lane_q == LAST_LANE);
`endif

  // --------------------------------------------------------------------------
  // FSM process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state logic (flush overrides every transition)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (w_fetch_last) state_d = w_any_lane ? S_STREAM : S_DONE;
      end
      S_STREAM: begin
        if (w_handshake && w_is_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush) state_d = S_IDLE;
  end

  // --------------------------------------------------------------------------
  // FSM process 3: outputs, all decoded from registered state
  // --------------------------------------------------------------------------
  logic [LW-1:0] w_lane_word;

  always_comb begin
    w_lane_word = '0;
    for (int i = 0; i < NSAT; i++) begin
      if (lane_q == IDXW'(i)) w_lane_word = clause_q[i*LW +: LW];
    end
  end

  always_comb begin
    busy_o        = (state_q != S_IDLE);
    mem_rd_en_o   = (state_q == S_FETCH) && (lat_cnt_q == '0);
    mem_addr_o    = addr_q;
    lit_valid_o   = (state_q == S_STREAM);
    lit_addr_o    = w_lane_word[LAW-1:0];
    lit_neg_o     = w_lane_word[LW-1];
    lit_idx_o     = lane_q;
    clause_done_o = (state_q == S_DONE);
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    addr_d    = w_accept ? clause_index_i : addr_q;
    clause_d  = w_capture ? mem_data_i : clause_q;

    lat_cnt_d = '0;
    if ((state_q == S_FETCH) && !flush && !w_fetch_last) begin
      lat_cnt_d = lat_cnt_q + LCW'(1);
    end

    // Lane counter returns to 0 when the clause ends or is aborted.
    lane_d = lane_q;
    if (flush) begin
      lane_d = '0;
    end else if (w_capture) begin
      lane_d = w_first_lane;
    end else if (w_handshake) begin
      lane_d = w_is_last ? '0 : w_next_lane;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt_q <= '0;
      lane_q    <= '0;
      clause_q  <= '0;
      addr_q    <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      lane_q    <= lane_d;
      clause_q  <= clause_d;
      addr_q    <= addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clause_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clause_fetch_sequencer
// Purpose  : Directed self-checking bench for clause_fetch_sequencer. Two
//            instances: MEM_LATENCY=1 (main) and MEM_LATENCY=3. A small
//            latency-accurate memory model returns the clause word only in
//            the cycle it is due; other cycles carry a garbage pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clause_fetch_sequencer;

  localparam int NSAT = 3;
  localparam int LAW  = 11;
  localparam int CAW  = 12;
  localparam int DW   = NSAT * (LAW + 1);
  localparam logic [DW-1:0] GARB = 36'hF5A_F5A_F5A;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           flush = 1'b0;
  logic           start_i = 1'b0;
  logic           start3 = 1'b0;
  logic           lit_ready_i = 1'b1;
  logic [CAW-1:0] clause_index_i = '0;
  logic [DW-1:0]  mem_data_i = '0;
  logic [DW-1:0]  mem_data3 = '0;

  logic           busy_o, mem_rd_en_o, lit_valid_o, lit_neg_o, clause_done_o;
  logic [CAW-1:0] mem_addr_o;
  logic [LAW-1:0] lit_addr_o;
  logic [1:0]     lit_idx_o;

  logic           busy3, mem_rd_en3, lit_valid3, lit_neg3, clause_done3;
  logic [CAW-1:0] mem_addr3;
  logic [LAW-1:0] lit_addr3;
  logic [1:0]     lit_idx3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clause_fetch_sequencer #(.NSAT(NSAT), .LITERAL_ADDRESS_WIDTH(LAW),
                           .CLAUSE_ADDRESS_WIDTH(CAW), .MEM_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .start_i(start_i),
    .clause_index_i(clause_index_i), .busy_o(busy_o), .mem_rd_en_o(mem_rd_en_o),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i), .lit_valid_o(lit_valid_o),
    .lit_ready_i(lit_ready_i), .lit_addr_o(lit_addr_o), .lit_neg_o(lit_neg_o),
    .lit_idx_o(lit_idx_o), .clause_done_o(clause_done_o));

  clause_fetch_sequencer #(.NSAT(NSAT), .LITERAL_ADDRESS_WIDTH(LAW),
                           .CLAUSE_ADDRESS_WIDTH(CAW), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .flush(1'b0), .start_i(start3),
    .clause_index_i(clause_index_i), .busy_o(busy3), .mem_rd_en_o(mem_rd_en3),
    .mem_addr_o(mem_addr3), .mem_data_i(mem_data3), .lit_valid_o(lit_valid3),
    .lit_ready_i(1'b1), .lit_addr_o(lit_addr3), .lit_neg_o(lit_neg3),
    .lit_idx_o(lit_idx3), .clause_done_o(clause_done3));

  wire [3:0]  ctrl  = {busy_o, mem_rd_en_o, lit_valid_o, clause_done_o};
  wire [13:0] lit   = {lit_idx_o, lit_neg_o, lit_addr_o};
  wire [3:0]  ctrl3 = {busy3, mem_rd_en3, lit_valid3, clause_done3};
  wire [13:0] lit3  = {lit_idx3, lit_neg3, lit_addr3};

  // Clause memory contents: {lane2, lane1, lane0}, each {neg, addr[10:0]}.
  function automatic logic [DW-1:0] mem_word(input logic [CAW-1:0] a);
    case (a)
      12'd5:   return {1'b0, 11'h456, 1'b1, 11'h07A, 1'b0, 11'h123};
      12'd6:   return {1'b0, 11'h022, 1'b0, 11'h000, 1'b0, 11'h011};
      12'd8:   return '0;
      12'd9:   return {1'b1, 11'h777, 1'b1, 11'h666, 1'b1, 11'h555};
      12'd12:  return {1'b0, 11'h302, 1'b1, 11'h301, 1'b0, 11'h300};
      default: return GARB;
    endcase
  endfunction

  // Memory model: read issued in cycle k returns data during cycle k+LATENCY.
  logic           pv [0:3] = '{default: 1'b0};
  logic [CAW-1:0] pa [0:3] = '{default: '0};
  logic           qv [0:3] = '{default: 1'b0};
  logic [CAW-1:0] qa [0:3] = '{default: '0};

  always @(posedge clk) begin
    #1;
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1]; pa[i] = pa[i-1];
      qv[i] = qv[i-1]; qa[i] = qa[i-1];
    end
    pv[0] = mem_rd_en_o; pa[0] = mem_addr_o;
    qv[0] = mem_rd_en3;  qa[0] = mem_addr3;
    mem_data_i = pv[1] ? mem_word(pa[1]) : GARB;
    mem_data3  = qv[3] ? mem_word(qa[3]) : GARB;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    vectors++;
    if ({ctrl, lit, mem_addr_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h required 0", {ctrl, lit, mem_addr_o});
    end
    vectors++;
    if ({ctrl3, lit3, mem_addr3} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_lat3 got %h required 0", {ctrl3, lit3, mem_addr3});
    end
    reset = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_basic();
    logic [3:0]  ec [0:7];
    logic [13:0] el [0:7];
    ec = '{4'b0000, 4'b1100, 4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1001, 4'b0000};
    el = '{default: '0};
    el[3] = {2'd0, 1'b0, 11'h123};
    el[4] = {2'd1, 1'b1, 11'h07A};
    el[5] = {2'd2, 1'b0, 11'h456};
    clause_index_i = 12'd5;
    start_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      vectors++;
      if (ctrl !== ec[c]) begin
        miscompares++;
        $display("FAIL basic_ctrl cyc%0d got %b required %b", c, ctrl, ec[c]);
      end
      if (ec[c][1]) begin
        vectors++;
        if (lit !== el[c]) begin
          miscompares++;
          $display("FAIL basic_lit cyc%0d got %h required %h", c, lit, el[c]);
        end
      end
      if (c == 1) begin
        vectors++;
        if (mem_addr_o !== 12'd5) begin
          miscompares++;
          $display("FAIL basic_addr got %0d required 5", mem_addr_o);
        end
      end
      tick();
      start_i = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall();
    logic [3:0]  ec [0:11];
    logic [13:0] el [0:11];
    ec = '{4'b0000, 4'b1100, 4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1010,
           4'b1010, 4'b1010, 4'b1010, 4'b1001, 4'b0000};
    el = '{default: '0};
    el[3] = {2'd0, 1'b0, 11'h123};
    for (int c = 4; c <= 8; c++) el[c] = {2'd1, 1'b1, 11'h07A};
    el[9] = {2'd2, 1'b0, 11'h456};
    clause_index_i = 12'd5;
    start_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      vectors++;
      if (ctrl !== ec[c]) begin
        miscompares++;
        $display("FAIL stall_ctrl cyc%0d got %b required %b", c, ctrl, ec[c]);
      end
      if (ec[c][1]) begin
        vectors++;
        if (lit !== el[c]) begin
          miscompares++;
          $display("FAIL stall_lit cyc%0d got %h required %h", c, lit, el[c]);
        end
      end
      tick();
      start_i = 1'b0;
      if (c + 1 == 4) lit_ready_i = 1'b0;
      if (c + 1 == 8) lit_ready_i = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_start_ignored();
    int dones;
    dones = 0;
    clause_index_i = 12'd5;
    start_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (clause_done_o === 1'b1) dones++;
      if (c >= 1) begin
        vectors++;
        if (mem_addr_o !== 12'd5) begin
          miscompares++;
          $display("FAIL ignore_addr cyc%0d got %0d required 5", c, mem_addr_o);
        end
      end
      if (c >= 3 && c <= 5) begin
        vectors++;
        if ({lit_valid_o, lit_idx_o} !== {1'b1, 2'(c - 3)}) begin
          miscompares++;
          $display("FAIL ignore_lane cyc%0d got %b required %b", c,
                   {lit_valid_o, lit_idx_o}, {1'b1, 2'(c - 3)});
        end
      end
      tick();
      start_i = 1'b0;
      if (c + 1 == 3) begin start_i = 1'b1; clause_index_i = 12'd9; end
      if (c + 1 == 4 || c + 1 == 5) start_i = 1'b1;
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL ignore_done_count got %0d required 1", dones);
    end
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_idle got %b required 0", busy_o);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    logic [3:0]  ec [0:7];
    logic [13:0] el [0:7];
    clause_index_i = 12'd5;
    start_i = 1'b1;
    tick(); start_i = 1'b0;      // cycle 1
    tick(); tick(); tick();      // cycle 4: lane 1
    flush = 1'b1;
    vectors++;
    if ({ctrl, lit} !== {4'b1010, 2'd1, 1'b1, 11'h07A}) begin
      miscompares++;
      $display("FAIL flush_pre got %h required %h", {ctrl, lit}, {4'b1010, 2'd1, 1'b1, 11'h07A});
    end
    tick();
    flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (ctrl !== 4'b0000) begin
        miscompares++;
        $display("FAIL flush_post cyc%0d got %b required 0000", c, ctrl);
      end
      tick();
    end
    // Flush and start together in IDLE: start is dropped.
    clause_index_i = 12'd9;
    start_i = 1'b1;
    flush = 1'b1;
    tick();
    start_i = 1'b0;
    flush = 1'b0;
    vectors++;
    if ({ctrl, mem_addr_o} !== {4'b0000, 12'd5}) begin
      miscompares++;
      $display("FAIL flush_start got %h required %h", {ctrl, mem_addr_o}, {4'b0000, 12'd5});
    end
    // A fresh fetch after the abort.
    ec = '{4'b0000, 4'b1100, 4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1001, 4'b0000};
    el = '{default: '0};
    el[3] = {2'd0, 1'b0, 11'h300};
    el[4] = {2'd1, 1'b1, 11'h301};
    el[5] = {2'd2, 1'b0, 11'h302};
    clause_index_i = 12'd12;
    start_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      vectors++;
      if (ctrl !== ec[c]) begin
        miscompares++;
        $display("FAIL refetch_ctrl cyc%0d got %b required %b", c, ctrl, ec[c]);
      end
      if (ec[c][1]) begin
        vectors++;
        if (lit !== el[c]) begin
          miscompares++;
          $display("FAIL refetch_lit cyc%0d got %h required %h", c, lit, el[c]);
        end
      end
      tick();
      start_i = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_latency3();
    logic [3:0]  ec [0:9];
    logic [13:0] el [0:9];
    ec = '{4'b0000, 4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b1010,
           4'b1010, 4'b1001, 4'b0000};
    el = '{default: '0};
    el[5] = {2'd0, 1'b0, 11'h123};
    el[6] = {2'd1, 1'b1, 11'h07A};
    el[7] = {2'd2, 1'b0, 11'h456};
    clause_index_i = 12'd5;
    start3 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (ctrl3 !== ec[c]) begin
        miscompares++;
        $display("FAIL lat3_ctrl cyc%0d got %b required %b", c, ctrl3, ec[c]);
      end
      if (ec[c][1]) begin
        vectors++;
        if (lit3 !== el[c]) begin
          miscompares++;
          $display("FAIL lat3_lit cyc%0d got %h required %h", c, lit3, el[c]);
        end
      end
      tick();
      start3 = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_skip_null();
    logic [3:0]  ec [0:7];
    logic [13:0] el [0:7];
    logic [CAW-1:0] idx;
    int n;
    for (int k = 0; k < 2; k++) begin
      el = '{default: '0};
      idx = (k == 0) ? 12'd6 : 12'd8;
`ifdef CLAUSE_SKIP_NULL_EN
      if (k == 0) begin
        ec = '{4'b0000, 4'b1100, 4'b1000, 4'b1010, 4'b1010, 4'b1001, 4'b0000, 4'b0000};
        el[3] = {2'd0, 1'b0, 11'h011};
        el[4] = {2'd2, 1'b0, 11'h022};
        n = 7;
      end else begin
        ec = '{4'b0000, 4'b1100, 4'b1000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        n = 5;
      end
`else
      ec = '{4'b0000, 4'b1100, 4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1001, 4'b0000};
      n = 8;
      if (k == 0) begin
        el[3] = {2'd0, 1'b0, 11'h011};
        el[4] = {2'd1, 1'b0, 11'h000};
        el[5] = {2'd2, 1'b0, 11'h022};
      end else begin
        el[3] = {2'd0, 1'b0, 11'h000};
        el[4] = {2'd1, 1'b0, 11'h000};
        el[5] = {2'd2, 1'b0, 11'h000};
      end
`endif
      clause_index_i = idx;
      start_i = 1'b1;
      for (int c = 0; c < n; c++) begin
        vectors++;
        if (ctrl !== ec[c]) begin
          miscompares++;
          $display("FAIL null_ctrl clause%0d cyc%0d got %b required %b", idx, c, ctrl, ec[c]);
        end
        if (ec[c][1]) begin
          vectors++;
          if (lit !== el[c]) begin
            miscompares++;
            $display("FAIL null_lit clause%0d cyc%0d got %h required %h", idx, c, lit, el[c]);
          end
        end
        tick();
        start_i = 1'b0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    clause_index_i = 12'd12;
    start_i = 1'b1;
    tick(); start_i = 1'b0;
    tick(); tick(); tick();      // cycle 4: lane 1 valid
    vectors++;
    if ({ctrl, lit} !== {4'b1010, 2'd1, 1'b1, 11'h301}) begin
      miscompares++;
      $display("FAIL rstmid_pre got %h required %h", {ctrl, lit}, {4'b1010, 2'd1, 1'b1, 11'h301});
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({ctrl, lit, mem_addr_o} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async got %h required 0", {ctrl, lit, mem_addr_o});
    end
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (ctrl !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstmid_after got %b required 0000", ctrl);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_flush();
    test_latency3();
    test_skip_null();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
